// File: rtl/acc28_block.sv
// ============================================================================
// acc28_block -- windowed signed accumulator with a valid/ready result port.
// Optional ACC28_SAT_EN: saturate on overflow (default build wraps mod 2^28).
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc28_block #(
  parameter int WIDTH = 27,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0]     S_IDLE   = 2'd0;
  localparam logic [1:0]     S_ACC    = 2'd1;
  localparam logic [1:0]     S_HOLD   = 2'd2;
  localparam logic [CNT_W:0] CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] CNT_FULL = {1'b1, {CNT_W{1'b0}}};
  localparam logic [WIDTH:0] SAT_MAX  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] SAT_MIN  = {1'b1, {WIDTH{1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             xfer_w;
  logic             last_w;
  logic             start_w;
  logic             done_w;
  logic [WIDTH+1:0] a_ext_w;
  logic [WIDTH+1:0] b_ext_w;
  logic [WIDTH+1:0] sum_w;
  logic             sum_ovf_w;
  logic [WIDTH:0]   result_w;

  assign start_w = (state_q == S_IDLE) && start;
  assign xfer_w  = (state_q == S_ACC) && in_valid;
  assign last_w  = xfer_w && (cnt_q == CNT_ONE);
  assign done_w  = out_valid_q && out_ready;

  // Extended-width add/sub: the top two bits disagree exactly on overflow.
  always_comb begin
    a_ext_w   = {acc_q[WIDTH], acc_q};
    b_ext_w   = {in_data[WIDTH], in_data};
    sum_w     = in_sub ? (a_ext_w - b_ext_w) : (a_ext_w + b_ext_w);
    sum_ovf_w = sum_w[WIDTH+1] ^ sum_w[WIDTH];
`ifdef ACC28_SAT_EN
    if (sum_ovf_w) begin
      result_w = sum_w[WIDTH+1] ? SAT_MIN : SAT_MAX;
    end else begin
      result_w = sum_w[WIDTH:0];
    end
`else
    result_w = sum_w[WIDTH:0];
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)   state_d = S_ACC;
      S_ACC:  if (last_w)  state_d = S_HOLD;
      S_HOLD: if (done_w)  state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state / registers only
  always_comb begin
    in_ready  = (state_q == S_ACC);
    busy      = (state_q != S_IDLE);
    out_valid = out_valid_q;
    out_data  = acc_q;
    out_ovf   = ovf_q;
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (start_w) begin
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = (len == '0) ? CNT_FULL : {1'b0, len};
    end else if (xfer_w) begin
      acc_d = result_w;
      ovf_d = ovf_q | sum_ovf_w;
      cnt_d = cnt_q - CNT_ONE;
    end
    if (last_w) begin
      out_valid_d = 1'b1;
    end else if (done_w) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_acc28_block.sv
// ============================================================================
// tb_acc28_block -- directed, table-driven self-checking bench for acc28_block.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_acc28_block;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic        in_sub;
  logic [27:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_data;
  logic        out_ovf;
  logic        busy;

  int n_cmp;
  int n_bad;

`ifdef ACC28_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  acc28_block #(.WIDTH(27), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0]       n;
    logic [3:0]       sub;
    logic [3:0][27:0] data;
    logic [27:0]      exp_data;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] l, input logic [2:0] n, input logic [3:0] sub,
                              input logic [27:0] d0, input logic [27:0] d1,
                              input logic [27:0] d2, input logic [27:0] d3,
                              input logic [27:0] e_sat, input logic [27:0] e_wrap,
                              input logic ovf);
    vec_t v;
    v.len      = l;
    v.n        = n;
    v.sub      = sub;
    v.data[0]  = d0;
    v.data[1]  = d1;
    v.data[2]  = d2;
    v.data[3]  = d3;
    v.exp_data = SAT ? e_sat : e_wrap;
    v.exp_ovf  = ovf;
    return v;
  endfunction

  task automatic start_block(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'hA5;
  endtask

  initial begin
    int k;
    int xfers;
    logic [27:0] held;

    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_sub = 1'b0;
    in_data = '0; out_ready = 1'b0;

    // sub bit i applies to operand i
    vecs[0] = mk(8'd3, 3'd3, 4'b0100, 28'd5, 28'd7, 28'hFFFFFFE, 28'd0,
                 28'd14, 28'd14, 1'b0);
    vecs[1] = mk(8'd2, 3'd2, 4'b0000, 28'h7FFFFF0, 28'h20, 28'd0, 28'd0,
                 28'h7FFFFFF, 28'h8000010, 1'b1);
    vecs[2] = mk(8'd1, 3'd1, 4'b0001, 28'h8000000, 28'd0, 28'd0, 28'd0,
                 28'h7FFFFFF, 28'h8000000, 1'b1);
    vecs[3] = mk(8'd2, 3'd2, 4'b0000, 28'h8000000, 28'hFFFFFFF, 28'd0, 28'd0,
                 28'h8000000, 28'h7FFFFFF, 1'b1);
    vecs[4] = mk(8'd4, 3'd4, 4'b1100, 28'h7FFFFFF, 28'd1, 28'd1, 28'h10,
                 28'h7FFFFEE, 28'h7FFFFEF, 1'b1);
    vecs[5] = mk(8'd2, 3'd2, 4'b0001, 28'd3, 28'd3, 28'd0, 28'd0,
                 28'd0, 28'd0, 1'b0);
    vecs[6] = mk(8'd1, 3'd1, 4'b0000, 28'hFFFFFFF, 28'd0, 28'd0, 28'd0,
                 28'hFFFFFFF, 28'hFFFFFFF, 1'b0);

    #2;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_out_data", {4'd0, out_data}, 32'd0);
    chk("reset_out_ovf", {31'd0, out_ovf}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // operands offered in IDLE are not consumed and do not start anything
    in_valid = 1'b1; in_data = 28'd99;
    tick(); tick();
    chk("idle_no_consume_busy", {31'd0, busy}, 32'd0);
    chk("idle_no_consume_data", {4'd0, out_data}, 32'd0);
    in_valid = 1'b0;

    for (int v = 0; v < 7; v++) begin
      start_block(vecs[v].len);
      chk($sformatf("v%0d_in_ready", v), {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        chk($sformatf("v%0d_no_early_valid", v), {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_sub   = vecs[v].sub[i];
        in_data  = vecs[v].data[i];
        tick();
      end
      in_valid = 1'b0; in_sub = 1'b0;
      chk($sformatf("v%0d_out_valid", v), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_out_data", v), {4'd0, out_data}, {4'd0, vecs[v].exp_data});
      chk($sformatf("v%0d_out_ovf", v), {31'd0, out_ovf}, {31'd0, vecs[v].exp_ovf});
      chk($sformatf("v%0d_hold_in_ready", v), {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_idle_busy", v), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_idle_valid", v), {31'd0, out_valid}, 32'd0);
    end

    // len = 0 -> 256 transfers with random valid gaps
    start_block(8'd0);
    xfers = 0;
    k = 0;
    while (xfers < 256 && k < 3000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_sub   = 1'b0;
      in_data  = 28'd1;
      if (in_valid && in_ready) xfers++;
      tick();
      k++;
    end
    in_valid = 1'b0;
    chk("len0_transfers", xfers, 32'd256);
    chk("len0_in_ready_dropped", {31'd0, in_ready}, 32'd0);
    chk("len0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("len0_out_data", {4'd0, out_data}, 32'd256);
    chk("len0_out_ovf", {31'd0, out_ovf}, 32'd0);

    // stalled result, start pulsed while holding
    held = out_data;
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      len   = 8'd5;
      tick();
      chk("hold_stable_data", {4'd0, out_data}, {4'd0, held});
      chk("hold_stable_valid", {31'd0, out_valid}, 32'd1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("hold_start_ignored", {31'd0, in_ready}, 32'd0);

    // reset mid-block after 2 of 4 operands
    start_block(8'd4);
    in_valid = 1'b1; in_sub = 1'b0; in_data = 28'd100;
    tick(); tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_out_data", {4'd0, out_data}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    start_block(8'd1);
    in_valid = 1'b1; in_data = 28'd9;
    tick();
    in_valid = 1'b0;
    chk("post_abort_valid", {31'd0, out_valid}, 32'd1);
    chk("post_abort_data", {4'd0, out_data}, 32'd9);
    chk("post_abort_ovf", {31'd0, out_ovf}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/acc28_block.md
# acc28_block

Block accumulator placed directly downstream of the team's 28-bit add/subtract stage. Accepts a stream of signed 28-bit operands, each tagged add or subtract, and accumulates a programmed number of them into a 28-bit two's-complement result. It then presents the result with a sticky overflow flag on a valid/ready output port. Used for windowed sums and differences in the arithmetic datapath.

## Interface
- WIDTH, 27, MSB index of data; data width is WIDTH+1 = 28 bits.
- CNT_W, 8, width of the block-length field.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a block; sampled only in IDLE.
- len  input  CNT_W  samples per block, latched on start; 0 means 2^CNT_W.
- in_valid  input  1  operand present.
- in_ready  output  1  block accepts operand; high exactly in ACC.
- in_sub  input  1  0: acc + in_data; 1: acc − in_data.
- in_data  input  WIDTH+1  signed operand.
- out_valid  output  1  result present (registered).
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH+1  signed accumulated result.
- out_ovf  output  1  at least one overflow occurred in this block (sticky).
- busy  output  1  state != IDLE.

## Operation
- States: IDLE, ACC, HOLD.
- IDLE → ACC on start:
  - acc ← 0; ovf ← 0.
  - cnt ← len, or 2^CNT_W when len = 0.
  - cnt is CNT_W+1 bits wide.
- ACC:
  - in_ready = 1.
  - Each cycle with in_valid & in_ready: acc updated and cnt decremented.
  - On the transfer where cnt = 1: go to HOLD and set out_valid.
- HOLD:
  - out_valid = 1; out_data = acc; out_ovf = ovf.
  - Outputs are stable until out_ready.
  - On out_valid & out_ready: go to IDLE and clear out_valid.
- start outside IDLE is ignored; len changes outside IDLE are ignored.
- Arithmetic:
  - Sign-extend acc and in_data to WIDTH+2 bits.
  - s = acc + in_data, or acc − in_data.
  - Overflow when s[WIDTH+1] != s[WIDTH]. On overflow, ovf ← 1 (sticky for the block).
  - Result written to acc depends on ACC28_SAT_EN (see Configuration).
  - Subtracting −2^27 is exact in the extended width; no special case.
- in_data with in_valid outside ACC is not consumed.

## Timing
- Reset values, asynchronous on rst:
  - state = IDLE; acc = 0; cnt = 0; ovf = 0.
  - in_ready = 0; out_valid = 0; out_data = 0; out_ovf = 0; busy = 0.
- rst mid-block aborts the block. The partial result is discarded; no out_valid.
- start accepted at edge N: in_ready high from cycle N+1.
- Throughput: one operand per cycle in ACC.
- Last operand accepted at edge M: out_valid high from cycle M+1.
- Result accepted at edge K: next start is accepted no earlier than edge K+1.
- in_ready is a function of state only; it never depends on in_valid.
- out_valid never depends combinationally on out_ready.

## Configuration
- ACC28_SAT_EN defined (saturating mode):
  - On overflow, acc ← 0x7FFFFFF if s is positive (s[WIDTH+1] = 0), else 0x8000000.
  - Later operands continue from the saturated value.
- ACC28_SAT_EN undefined (wrapping mode):
  - acc ← s[WIDTH:0], i.e. modulo 2^28.
  - out_ovf still reports overflow.

## Test plan
- Reset, then len = 3 with operands +5, +7, sub −2 (in_sub = 1, in_data = −2) back-to-back -> out_valid one cycle after the third operand; out_data = 14; out_ovf = 0.
- len = 2 with operands 0x7FFFFF0 and +0x20 -> with ACC28_SAT_EN: out_data = 0x7FFFFFF, out_ovf = 1; without: out_data = 0x8000010, out_ovf = 1.
- len = 1, sub 0x8000000 (i.e. 0 − (−2^27)) -> with ACC28_SAT_EN: 0x7FFFFFF, ovf = 1; without: 0x8000000, ovf = 1.
- len = 0, feeding 256 operands of +1 with random in_valid gaps -> exactly 256 transfers; out_data = 256; in_ready drops the cycle after the 256th transfer.
- Result pending with out_ready low for 10 cycles, start pulsed meanwhile -> out_data stable and start ignored; after out_ready, busy = 0 next cycle.
- rst asserted after 2 of 4 operands -> all outputs 0 immediately; a new block afterwards with len = 1, +9 -> out_data = 9.
